relu_maxpool2d: RTL and testbench
=================================

# relu_maxpool2d

Fused ReLU and 2×2 max-pool stage that sits directly downstream of the convolution layer. After the conv layer's `done`, it streams the conv feature-map BRAM one read per cycle and reduces each POOL×POOL window to max(0, window max). It writes the pooled map into a separate pool-buffer BRAM for the next layer. The block is read-only on the conv buffer and write-only on the pool buffer.

## Interface
- `DATA_WIDTH`, default 16: signed fixed-point word width. The format is unchanged by this stage, so there is no FRAC_BITS handling.
- `CHANNELS`, default 8: feature-map channels; equals the conv layer's OUT_CHANNELS.
- `IMG_SIZE`, default 28: input height and width.
- `POOL`, default 2: window size and stride.
- Derived: `OUT_SIZE` = IMG_SIZE/POOL (floor); `IN_AW` = $clog2(CHANNELS·IMG_SIZE²); `OUT_AW` = $clog2(CHANNELS·OUT_SIZE²).

Ports (clock and reset first):
- `clk`  in  1: single clock; everything is on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse that begins a full pass.
- `conv_addr`  out  IN_AW: conv buffer read address (registered).
- `conv_en`  out  1: conv buffer read enable (registered).
- `conv_q`  in  DATA_WIDTH signed: conv buffer read data.
- `pool_addr`  out  OUT_AW: pool buffer write address (registered).
- `pool_en`  out  1: pool buffer enable (registered).
- `pool_we`  out  1: pool buffer write enable (registered).
- `pool_d`  out  DATA_WIDTH signed: pool buffer write data (registered).
- `done`  out  1: one-cycle pulse after the last write.

## Operation
- **Reset values:** every output is 0, FSM is IDLE, all counters are 0.
- **FSM states:**
  - IDLE: `start` high → ISSUE.
  - ISSUE: ends after the last read is issued → DRAIN.
  - DRAIN: 2 cycles, so the last read returns and its write is registered → FINISH.
  - FINISH: `done`=1 for one cycle → IDLE.
- **Start handling:** `start` outside IDLE is ignored.
- **Loop order:** ch outer, then prow, then pcol, then window element w = dy·POOL+dx, which runs (0,0),(0,1),(1,0),(1,1).
- **Read address:** (ch·IMG_SIZE + POOL·prow + dy)·IMG_SIZE + POOL·pcol + dx.
- **Write address:** (ch·OUT_SIZE + prow)·OUT_SIZE + pcol.
- **Read rate:** one read per cycle, no bubbles, for N = CHANNELS·OUT_SIZE²·POOL² reads. With defaults N = 6272.
- **Read-data tagging:** a 2-stage valid/last pipeline travels alongside each read. It marks which returning `conv_q` belongs to which window and whether it is the window's final element.
- **Window reduction:**
  - The running max register is initialised to 0 at the first element of each window. This folds ReLU in, so negatives clamp to 0.
  - Update: m ← (conv_q > m) ? conv_q : m, as a signed compare at full DATA_WIDTH.
  - There is no widening or saturation: the result lies in [0, S_MAX].
- **Window write:** on the final element, `pool_d` = final max and `pool_en`=`pool_we`=1 for exactly one cycle. Writes are spaced POOL² cycles apart.
- **Odd IMG_SIZE:** the last row and column are never read (floor pooling).
- **Reset mid-pass:** outputs return to 0 immediately (asynchronously) and no further writes occur. A new `start` is required afterwards.
- **Pulse shape:** `conv_en` is high only in cycles that carry a valid address. Every other cycle, `pool_we`/`pool_en` are 0.

## Timing
- **BRAM contract:** synchronous read, 1-cycle latency. An address registered at edge E is sampled by the BRAM at E+1, and `conv_q` is captured by this block at E+2.
- **Read k:** with `start` sampled at edge S, the k-th read is registered at edge S+1+k and captured at edge S+3+k.
- **Write of window j:** registered at edge S+3+POOL²·j+(POOL²−1).
- **Done:** the last write is registered at edge S+N+2, and `done` is registered high at edge S+N+3 for one cycle. With defaults, `done` rises 6275 edges after S.
- **Back-to-back start:** a `start` in the cycle `done` is high is ignored, because the FSM is in FINISH. A `start` one cycle later is accepted.

## Structure
- The shared package `cnn_pkg` holds:
  - the `lin3(ch,row,col,H,W)` address function;
  - the `data_t` signed DATA_WIDTH typedef;
  - the S_MAX/S_MIN constants, shared with the conv stage.
- Sub-module `pool_window_addr_gen` holds the ch/prow/pcol/dy/dx counters. Its outputs are the read address, a first flag, a last flag, the write address and an end-of-pass flag. It advances one element per enabled cycle.
- The top level holds the FSM, the 2-stage tag pipeline, the max register and the output registers.

## Test plan
- **Basic pool, single channel:** CHANNELS=1, IMG_SIZE=4, ramp conv = 0..15 → pool = {5,7,13,15} at addresses 0..3; `done` 19 edges after `start` (N=16).
- **All negative:** every conv value = −100 (0xFF9C) → every pool word = 0x0000.
- **Mixed window:** window {−5, 3, −32768, 32767} → 32767. Window {−1, 0, 0, −2} → 0.
- **Odd size:** IMG_SIZE=5, last row and column set to 0x7FFF, all other values 1 → every output = 1, and row/column 4 addresses are never read.
- **Default sweep:** random conv data compared against a reference model → 1568 writes, each exactly once, with `pool_we` never high in consecutive cycles.
- **Reset and start misuse:**
  - `reset` low at read 100 → outputs 0 within the same cycle, no writes afterwards.
  - After release, a fresh `start` produces a complete correct pass.
  - A `start` pulse during ISSUE is ignored.

Source files
------------

// File: rtl/cnn_pkg.sv
// +--------------------------------------------------------------------+
// | cnn_pkg : types, constants and address helpers shared by CNN stages |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 16;

  typedef logic signed [CNN_DATA_WIDTH-1:0] data_t;

  localparam data_t S_MAX = {1'b0, {(CNN_DATA_WIDTH-1){1'b1}}};
  localparam data_t S_MIN = {1'b1, {(CNN_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } pool_state_t;

  // Row-major linear address of (ch,row,col) in a CH x H x W map.
  function automatic int lin3(input int ch, input int row, input int col,
                              input int h, input int w);
    return (ch * h + row) * w + col;
  endfunction

endpackage

`default_nettype wire

// File: rtl/relu_maxpool2d_if.sv
// +--------------------------------------------------------------------+
// | relu_maxpool2d_if : control + conv/pool BRAM bus of relu_maxpool2d  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface relu_maxpool2d_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_AW      = 13,
  parameter int OUT_AW     = 11
);
  logic                         start;
  logic [IN_AW-1:0]             conv_addr;
  logic                         conv_en;
  logic signed [DATA_WIDTH-1:0] conv_q;
  logic [OUT_AW-1:0]            pool_addr;
  logic                         pool_en;
  logic                         pool_we;
  logic signed [DATA_WIDTH-1:0] pool_d;
  logic                         done;

  modport master (
    input  start, conv_q,
    output conv_addr, conv_en, pool_addr, pool_en, pool_we, pool_d, done
  );

  modport slave (
    output start, conv_q,
    input  conv_addr, conv_en, pool_addr, pool_en, pool_we, pool_d, done
  );
endinterface

`default_nettype wire

// File: rtl/pool_window_addr_gen.sv
// +--------------------------------------------------------------------+
// | pool_window_addr_gen : ch/prow/pcol/dy/dx walk over pooling windows |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module pool_window_addr_gen
  import cnn_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int IMG_SIZE = 28,
  parameter int POOL     = 2,
  parameter int IN_AW    = 13,
  parameter int OUT_AW   = 11
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              en,
  output logic [IN_AW-1:0]       rd_addr,
  output logic                   first,
  output logic                   last,
  output logic [OUT_AW-1:0]      wr_addr,
  output logic                   eop
);
  localparam int OUT_SIZE = IMG_SIZE / POOL;
  localparam int CW = $clog2(CHANNELS + 1);
  localparam int PW = $clog2(OUT_SIZE + 1);
  localparam int DW = $clog2(POOL + 1);

  logic [CW-1:0] r_ch;
  logic [PW-1:0] r_prow, r_pcol;
  logic [DW-1:0] r_dy, r_dx;

  logic w_dx_end, w_dy_end, w_pcol_end, w_prow_end, w_ch_end;

  assign w_dx_end   = (r_dx   == DW'(POOL - 1));
  assign w_dy_end   = (r_dy   == DW'(POOL - 1));
  assign w_pcol_end = (r_pcol == PW'(OUT_SIZE - 1));
  assign w_prow_end = (r_prow == PW'(OUT_SIZE - 1));
  assign w_ch_end   = (r_ch   == CW'(CHANNELS - 1));

  // Nested odometer: dx fastest, ch slowest; wraps to zero after the pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ch   <= '0;
      r_prow <= '0;
      r_pcol <= '0;
      r_dy   <= '0;
      r_dx   <= '0;
    end else if (en) begin
      if (!w_dx_end) begin
        r_dx <= r_dx + DW'(1);
      end else begin
        r_dx <= '0;
        if (!w_dy_end) begin
          r_dy <= r_dy + DW'(1);
        end else begin
          r_dy <= '0;
          if (!w_pcol_end) begin
            r_pcol <= r_pcol + PW'(1);
          end else begin
            r_pcol <= '0;
            if (!w_prow_end) begin
              r_prow <= r_prow + PW'(1);
            end else begin
              r_prow <= '0;
              r_ch   <= w_ch_end ? '0 : r_ch + CW'(1);
            end
          end
        end
      end
    end
  end

  assign rd_addr = IN_AW'(lin3(int'(r_ch),
                               POOL * int'(r_prow) + int'(r_dy),
                               POOL * int'(r_pcol) + int'(r_dx),
                               IMG_SIZE, IMG_SIZE));
  assign wr_addr = OUT_AW'(lin3(int'(r_ch), int'(r_prow), int'(r_pcol),
                                OUT_SIZE, OUT_SIZE));
  assign first   = (r_dx == '0) && (r_dy == '0);
  assign last    = w_dx_end && w_dy_end;
  assign eop     = last && w_pcol_end && w_prow_end && w_ch_end;

endmodule

`default_nettype wire

// File: rtl/relu_maxpool2d.sv
// +--------------------------------------------------------------------+
// | relu_maxpool2d : fused ReLU + POOLxPOOL max-pool, conv BRAM -> pool |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module relu_maxpool2d
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IMG_SIZE   = 28,
  parameter int POOL       = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  relu_maxpool2d_if.master  bus
);
  localparam int OUT_SIZE = IMG_SIZE / POOL;
  localparam int IN_AW    = $clog2(CHANNELS * IMG_SIZE * IMG_SIZE);
  localparam int OUT_AW   = $clog2(CHANNELS * OUT_SIZE * OUT_SIZE);

  pool_state_t r_state;
  logic [1:0]  r_drain;

  logic [IN_AW-1:0]  w_rd_addr;
  logic [OUT_AW-1:0] w_wr_addr;
  logic              w_first, w_last, w_eop, w_issue;

  assign w_issue = (r_state == ST_ISSUE);

  pool_window_addr_gen #(
    .CHANNELS (CHANNELS),
    .IMG_SIZE (IMG_SIZE),
    .POOL     (POOL),
    .IN_AW    (IN_AW),
    .OUT_AW   (OUT_AW)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (w_issue),
    .rd_addr (w_rd_addr),
    .first   (w_first),
    .last    (w_last),
    .wr_addr (w_wr_addr),
    .eop     (w_eop)
  );

  // Tags ride two stages so they line up with conv_q of the same read.
  logic              r_t1_valid, r_t1_first, r_t1_last;
  logic              r_t2_valid, r_t2_first, r_t2_last;
  logic [OUT_AW-1:0] r_t1_waddr, r_t2_waddr;

  logic signed [DATA_WIDTH-1:0] r_max, w_base, w_next;

  logic [IN_AW-1:0]             r_conv_addr;
  logic                         r_conv_en;
  logic [OUT_AW-1:0]            r_pool_addr;
  logic                         r_pool_en, r_pool_we, r_done;
  logic signed [DATA_WIDTH-1:0] r_pool_d;

  // Seeding the max with 0 at each window start is what applies the ReLU.
  assign w_base = r_t2_first ? '0 : r_max;
  assign w_next = (bus.conv_q > w_base) ? bus.conv_q : w_base;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_drain     <= '0;
      r_conv_addr <= '0;
      r_conv_en   <= 1'b0;
      r_pool_addr <= '0;
      r_pool_en   <= 1'b0;
      r_pool_we   <= 1'b0;
      r_pool_d    <= '0;
      r_done      <= 1'b0;
      r_max       <= '0;
      r_t1_valid  <= 1'b0;
      r_t1_first  <= 1'b0;
      r_t1_last   <= 1'b0;
      r_t1_waddr  <= '0;
      r_t2_valid  <= 1'b0;
      r_t2_first  <= 1'b0;
      r_t2_last   <= 1'b0;
      r_t2_waddr  <= '0;
    end else begin
      r_conv_en <= 1'b0;
      r_pool_en <= 1'b0;
      r_pool_we <= 1'b0;
      r_done    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.start) r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_conv_en   <= 1'b1;
          r_conv_addr <= w_rd_addr;
          if (w_eop) begin
            r_state <= ST_DRAIN;
            r_drain <= '0;
          end
        end
        ST_DRAIN: begin
          if (r_drain == 2'd2) begin
            r_state <= ST_FINISH;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain + 2'd1;
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase

      r_t1_valid <= w_issue;
      r_t1_first <= w_first;
      r_t1_last  <= w_last;
      r_t1_waddr <= w_wr_addr;
      r_t2_valid <= r_t1_valid;
      r_t2_first <= r_t1_first;
      r_t2_last  <= r_t1_last;
      r_t2_waddr <= r_t1_waddr;

      if (r_t2_valid) begin
        r_max <= w_next;
        if (r_t2_last) begin
          r_pool_en   <= 1'b1;
          r_pool_we   <= 1'b1;
          r_pool_d    <= w_next;
          r_pool_addr <= r_t2_waddr;
        end
      end
    end
  end

  assign bus.conv_addr = r_conv_addr;
  assign bus.conv_en   = r_conv_en;
  assign bus.pool_addr = r_pool_addr;
  assign bus.pool_en   = r_pool_en;
  assign bus.pool_we   = r_pool_we;
  assign bus.pool_d    = r_pool_d;
  assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_relu_maxpool2d.sv
// +--------------------------------------------------------------------+
// | tb_relu_maxpool2d : directed bench, 2 channels of an odd 5x5 map    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_relu_maxpool2d;
  localparam int DW     = 16;
  localparam int CH     = 2;
  localparam int IMG    = 5;
  localparam int P      = 2;
  localparam int OS     = IMG / P;
  localparam int NRD    = CH * OS * OS * P * P;
  localparam int NWR    = CH * OS * OS;
  localparam int IN_AW  = $clog2(CH * IMG * IMG);
  localparam int OUT_AW = $clog2(CH * OS * OS);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  relu_maxpool2d_if #(.DATA_WIDTH(DW), .IN_AW(IN_AW), .OUT_AW(OUT_AW)) bus();

  relu_maxpool2d #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH),
    .IMG_SIZE   (IMG),
    .POOL       (P)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic signed [DW-1:0] mem      [0:(1<<IN_AW)-1];
  logic signed [DW-1:0] exp_pool [0:NWR-1];
  logic signed [DW-1:0] pool_mem [0:NWR-1];
  int                   wr_count [0:NWR-1];

  int checks = 0, errors = 0;
  int cyc = 0, s_edge = 0, rd_k = 0, wr_j = 0;
  bit active = 1'b0, prev_we = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Conv buffer: synchronous read, one cycle latency
  always @(posedge clk) if (bus.conv_en) bus.conv_q <= mem[bus.conv_addr];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pooled value = window maximum, then clamped at zero.
  task automatic build_model();
    for (int ch = 0; ch < CH; ch++)
      for (int pr = 0; pr < OS; pr++)
        for (int pc = 0; pc < OS; pc++) begin
          logic signed [DW-1:0] wmax, v;
          wmax = mem[(ch * IMG + P * pr) * IMG + P * pc];
          for (int dy = 0; dy < P; dy++)
            for (int dx = 0; dx < P; dx++) begin
              v = mem[(ch * IMG + P * pr + dy) * IMG + P * pc + dx];
              if (v > wmax) wmax = v;
            end
          exp_pool[(ch * OS + pr) * OS + pc] = (wmax < 0) ? '0 : wmax;
        end
  endtask

  function automatic int exp_rd_addr(input int k);
    int w, win, dy, dx, pc, pr, ch;
    w   = k % (P * P);
    win = k / (P * P);
    dy  = w / P;
    dx  = w % P;
    pc  = win % OS;
    pr  = (win / OS) % OS;
    ch  = win / (OS * OS);
    return ch * IMG * IMG + (P * pr + dy) * IMG + P * pc + dx;
  endfunction

  // Cycle-by-cycle comparison of the bus against the expected pass.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.conv_en) begin
        if (!active || rd_k >= NRD) chk("rd_unexpected", bus.conv_en, 0);
        else begin
          chk("rd_addr", bus.conv_addr, exp_rd_addr(rd_k));
          chk("rd_cycle", cyc - s_edge, 1 + rd_k);
          chk("rd_skips_last_row_col",
              (int'(bus.conv_addr) % IMG == IMG - 1) ||
              ((int'(bus.conv_addr) / IMG) % IMG == IMG - 1), 0);
          rd_k++;
        end
      end
      chk("pool_en_eq_we", bus.pool_en, bus.pool_we);
      if (bus.pool_we) begin
        chk("we_spacing", prev_we, 0);
        if (!active || wr_j >= NWR) chk("wr_unexpected", bus.pool_we, 0);
        else begin
          chk("wr_addr", bus.pool_addr, wr_j);
          chk("wr_data", bus.pool_d, exp_pool[wr_j]);
          chk("wr_cycle", cyc - s_edge, 3 + P * P * wr_j + (P * P - 1));
          pool_mem[bus.pool_addr] = bus.pool_d;
          wr_count[bus.pool_addr]++;
          wr_j++;
        end
      end
      prev_we = bus.pool_we;
      if (active && cyc == s_edge + NRD + 3) begin
        chk("done_pulse", bus.done, 1);
        chk("reads_total", rd_k, NRD);
        chk("writes_total", wr_j, NWR);
        for (int i = 0; i < NWR; i++) chk("write_once", wr_count[i], 1);
        active = 1'b0;
      end else if (bus.done) begin
        chk("done_unexpected", bus.done, 0);
      end
    end
  end

  task automatic start_pass();
    build_model();
    rd_k = 0;
    wr_j = 0;
    for (int i = 0; i < NWR; i++) begin
      wr_count[i] = 0;
      pool_mem[i] = 16'sh5A5A;
    end
    active = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 s_edge = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (active && n < NRD + 20) begin
      @(negedge clk);
      n++;
    end
    if (active) begin
      chk("pass_timeout", active, 0);
      active = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_conv_addr"}, bus.conv_addr, 0);
    chk({tag, "_conv_en"},   bus.conv_en,   0);
    chk({tag, "_pool_addr"}, bus.pool_addr, 0);
    chk({tag, "_pool_en"},   bus.pool_en,   0);
    chk({tag, "_pool_we"},   bus.pool_we,   0);
    chk({tag, "_pool_d"},    bus.pool_d,    0);
    chk({tag, "_done"},      bus.done,      0);
  endtask

  int ramp_exp [NWR] = '{6, 8, 16, 18, 31, 33, 41, 43};

  initial begin
    int n;
    bus.start  = 1'b0;
    bus.conv_q = '0;
    for (int i = 0; i < (1 << IN_AW); i++) mem[i] = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Ramp: each window max is its bottom-right element
    for (int i = 0; i < CH * IMG * IMG; i++) mem[i] = DW'(i);
    start_pass(); wait_end();
    for (int i = 0; i < NWR; i++) chk("ramp_literal", pool_mem[i], ramp_exp[i]);

    // All negative clamps to zero
    for (int i = 0; i < CH * IMG * IMG; i++) mem[i] = -16'sd100;
    start_pass(); wait_end();
    for (int i = 0; i < NWR; i++) chk("neg_literal", pool_mem[i], 0);

    // Mixed windows including both extremes
    for (int i = 0; i < CH * IMG * IMG; i++) mem[i] = -16'sd7;
    mem[0] = -16'sd5; mem[1] = 16'sd3; mem[5] = 16'sh8000; mem[6] = 16'sh7FFF;
    mem[2] = -16'sd1; mem[3] = 16'sd0; mem[7] = 16'sd0;    mem[8] = -16'sd2;
    start_pass(); wait_end();
    chk("mixed_w0", pool_mem[0], 32767);
    chk("mixed_w1", pool_mem[1], 0);
    chk("mixed_w2", pool_mem[2], 0);

    // Odd size: the unread last row/column holds the largest value
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < IMG; r++)
        for (int k = 0; k < IMG; k++)
          mem[(c * IMG + r) * IMG + k] = (r == IMG - 1 || k == IMG - 1) ? 16'sh7FFF : 16'sd1;
    start_pass(); wait_end();
    for (int i = 0; i < NWR; i++) chk("odd_literal", pool_mem[i], 1);

    // Random data with a stray start pulse mid-ISSUE
    for (int i = 0; i < CH * IMG * IMG; i++) mem[i] = DW'($urandom);
    start_pass();
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_end();

    // Back-to-back: start during done ignored, held one more cycle accepted
    for (int i = 0; i < CH * IMG * IMG; i++) mem[i] = DW'($urandom);
    start_pass();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < NRD + 20);
    chk("b2b_done_seen", bus.done, 1);
    bus.start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < CH * IMG * IMG; i++) mem[i] = DW'($urandom);
    start_pass();
    wait_end();

    // Reset mid-pass
    for (int i = 0; i < CH * IMG * IMG; i++) mem[i] = DW'($urandom);
    start_pass();
    n = 0;
    while (rd_k < 10 && n < NRD + 20) begin
      @(negedge clk);
      n++;
    end
    chk("reset_point_reached", rd_k >= 10, 1);
    reset  = 1'b0;
    active = 1'b0;
    #1 check_outputs_zero("midreset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (NRD) begin
      @(negedge clk);
      chk("idle_after_reset_we", bus.pool_we, 0);
    end
    for (int i = 0; i < CH * IMG * IMG; i++) mem[i] = DW'($urandom);
    start_pass();
    wait_end();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
